// File: rtl/acq_pkg.sv
// acq_pkg: shared types and constants for the acquisition scan sequencer.
// Command word layout, status bit indices and the scan FSM state encoding.
package acq_pkg;

  localparam int NUM_CH   = 8;
  localparam int CH_W     = $clog2(NUM_CH);
  localparam int PERIOD_W = 16;
  localparam int TMO_W    = 8;

  localparam int CMD_START_BIT = 31;
  localparam int CMD_CH_LSB    = 8;
  localparam int CMD_OP_LSB    = 0;

  localparam int DONE = 0;
  localparam int ERR  = 1;
  localparam int BUSY = 2;

  // A programmed timeout of 0 selects the full 2**TMO_W window
  localparam logic [TMO_W:0] TMO_FULL = {1'b1, {TMO_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_NEXT
  } acq_state_e;

  function automatic logic [31:0] mk_cmd(
    input logic            start,
    input logic [CH_W-1:0] ch,
    input logic [3:0]      op
  );
    logic [31:0] c;
    c = '0;
    c[CMD_START_BIT]         = start;
    c[CMD_CH_LSB +: CH_W]    = ch;
    c[CMD_OP_LSB +: 4]       = op;
    return c;
  endfunction

endpackage

// File: rtl/acq_next_chan.sv
// acq_next_chan: priority finder for the next enabled channel.
// i_first searches from bit 0 inclusive; otherwise strictly above i_cur.
module acq_next_chan
  import acq_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  input  logic              i_first,
  output logic [CH_W-1:0]   o_chan,
  output logic              o_found
);

  always_comb begin
    o_chan  = '0;
    o_found = 1'b0;
    // Descending walk so the lowest qualifying bit is the last to win
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_chan  = CH_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acq_scan_sequencer.sv
// acq_scan_sequencer: periodic masked channel scanner that issues core
// commands, waits for done/timeout and writes results downstream.
module acq_scan_sequencer
  import acq_pkg::*;
(
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cfg_en,
  input  logic [NUM_CH-1:0]   cfg_mask,
  input  logic [3:0]          cfg_op,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [TMO_W-1:0]    cfg_timeout,
  output logic [31:0]         core_cmd,
  input  logic [2:0]          core_status,
  input  logic [31:0]         core_result,
  output logic                res_valid,
  output logic [CH_W-1:0]     res_chan,
  output logic [31:0]         res_data,
  output logic                res_err,
  output logic                scan_done,
  output logic                overrun,
  output logic                busy
);

  acq_state_e          r_state;
  logic [NUM_CH-1:0]   r_mask;
  logic [3:0]          r_op;
  logic [CH_W-1:0]     r_chan;
  logic [CH_W-1:0]     r_nxt;
  logic                r_last;
  logic [PERIOD_W-1:0] r_period;
  logic [TMO_W:0]      r_tmo;
  logic                r_en_d;
  logic [31:0]         r_cmd;
  logic                r_res_valid;
  logic [CH_W-1:0]     r_res_chan;
  logic [31:0]         r_res_data;
  logic                r_res_err;
  logic                r_scan_done;
  logic                r_overrun;
  logic                r_busy;

  logic                w_idle;
  logic                w_start_ok;
  logic                w_en_rise;
  logic                w_done;
  logic                w_err;
  logic                w_tmo_hit;
  logic                w_stop;
  logic                w_found;
  logic                w_unused;
  logic [CH_W-1:0]     w_next;
  logic [NUM_CH-1:0]   w_src_mask;
  logic [TMO_W:0]      w_tmo_eff;
  logic [PERIOD_W-1:0] w_period_ld;

  assign w_idle     = (r_state == S_IDLE);
  assign w_done     = core_status[DONE];
  assign w_err      = core_status[ERR];
  assign w_unused   = core_status[BUSY];
  assign w_en_rise  = cfg_en && !r_en_d;
  assign w_tmo_hit  = (r_tmo == (TMO_W+1)'(1));
  assign w_src_mask = w_idle ? cfg_mask : r_mask;

  assign w_start_ok = cfg_en && (cfg_mask != '0)
                   && (r_period == '0);

  assign w_tmo_eff = (cfg_timeout == '0)
                   ? TMO_FULL
                   : {1'b0, cfg_timeout};

  assign w_period_ld = (cfg_period == '0)
                     ? '0
                     : cfg_period - 1'b1;

  // cfg_en is sampled in CAPTURE so scan_done can be registered into NEXT
  assign w_stop = !w_found || !cfg_en;

  acq_next_chan u_next (
    .i_mask  (w_src_mask),
    .i_cur   (r_chan),
    .i_first (w_idle),
    .o_chan  (w_next),
    .o_found (w_found)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_op        <= '0;
      r_chan      <= '0;
      r_nxt       <= '0;
      r_last      <= 1'b0;
      r_period    <= '0;
      r_tmo       <= '0;
      r_en_d      <= 1'b0;
      r_cmd       <= '0;
      r_res_valid <= 1'b0;
      r_res_chan  <= '0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_scan_done <= 1'b0;
      r_overrun   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_en_d      <= cfg_en;
      r_res_valid <= 1'b0;
      r_scan_done <= 1'b0;

      if (r_period != '0) begin
        r_period <= r_period - 1'b1;
      end

      if (w_en_rise) begin
        r_overrun <= 1'b0;
      end else if ((r_period == PERIOD_W'(1)) && !w_idle) begin
        r_overrun <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_period <= w_period_ld;
            r_mask   <= cfg_mask;
            r_op     <= cfg_op;
            r_chan   <= w_next;
            r_cmd    <= mk_cmd(1'b1, w_next, cfg_op);
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cmd   <= mk_cmd(1'b0, r_chan, r_op);
          r_tmo   <= w_tmo_eff;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done || w_tmo_hit) begin
            r_res_valid <= 1'b1;
            r_res_chan  <= r_chan;
            r_res_data  <= w_done ? core_result : '0;
            r_res_err   <= w_done ? w_err : 1'b1;
            r_state     <= S_CAPTURE;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        S_CAPTURE: begin
          r_nxt       <= w_next;
          r_last      <= w_stop;
          r_scan_done <= w_stop;
          r_state     <= S_NEXT;
        end
        S_NEXT: begin
          if (r_last) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_chan  <= r_nxt;
            r_cmd   <= mk_cmd(1'b1, r_nxt, r_op);
            r_state <= S_ISSUE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign core_cmd  = r_cmd;
  assign res_valid = r_res_valid;
  assign res_chan  = r_res_chan;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign scan_done = r_scan_done;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: doc/acq_scan_sequencer.md
# acq_scan_sequencer

Autonomous scan controller that sits between the APB register block and the data acquisition core. It replaces direct CPU writes of the command word. It steps through a masked set of the 8 sensor channels at a programmable period. For each channel it issues one acquisition command to the core, waits for completion or timeout, and writes each result with its channel index into a downstream result buffer. The CPU configures it and receives a per-scan interrupt pulse.

## Interface
- NUM_CH, 8, number of sensor channels; channel index width CH_W = $clog2(NUM_CH)
- PERIOD_W, 16, width of scan period counter
- TMO_W, 8, width of per-channel timeout counter
- PCLK  in  1  clock, shared with APB and core
- PRESET  in  1  synchronous, active-high reset
- cfg_en  in  1  level; 1 = scanning allowed
- cfg_mask  in  NUM_CH  channel enable mask; bit i = channel i
- cfg_op  in  4  operation code placed in the command word
- cfg_period  in  PERIOD_W  PCLK cycles from one scan start to the next
- cfg_timeout  in  TMO_W  max WAIT cycles per channel; 0 = 256
- core_cmd  out  32  command word to core; fields: [31] START, [10:8] channel, [3:0] op, other bits 0
- core_status  in  3  {busy, err_sticky, done} from core
- core_result  in  32  core result word
- res_valid  out  1  one-cycle write strobe to result buffer
- res_chan  out  CH_W  channel of the written result
- res_data  out  32  result word
- res_err  out  1  1 = core error or timeout for this channel
- scan_done  out  1  one-cycle pulse at end of each scan
- overrun  out  1  sticky; cleared by a rising edge of cfg_en or by reset
- busy  out  1  1 whenever the state is not IDLE

## Operation
- Reset values: core_cmd=0, res_valid=0, res_chan=0, res_data=0, res_err=0, scan_done=0, overrun=0, busy=0, state IDLE, period counter 0.
- States: IDLE, ISSUE, WAIT, CAPTURE, NEXT.
- IDLE -> ISSUE: requires cfg_en=1, cfg_mask≠0 and period counter=0. On this transition the period counter loads cfg_period-1, or 0 when cfg_period=0, meaning back-to-back scans. The channel pointer loads the lowest set mask bit.
- ISSUE (1 cycle): core_cmd = {START=1, chan, cfg_op}. The timeout counter loads the effective timeout. Then go to WAIT.
- WAIT: core_cmd keeps chan and op with START=0.
  - If done=1, go to CAPTURE with err = err_sticky.
  - If the timeout counter reaches 0, go to CAPTURE with err=1 and res_data=0.
  - If done and timeout occur in the same cycle, done wins.
- CAPTURE (1 cycle): res_valid=1 with res_chan, res_data=core_result and res_err. Then go to NEXT.
- NEXT (1 cycle): the pointer moves to the next higher set mask bit.
  - If a higher set bit exists, go to ISSUE.
  - Otherwise pulse scan_done and go to IDLE.
- cfg_mask and cfg_op are sampled once at scan start. Changes during a scan take effect at the next scan.
- If cfg_en falls mid-scan, the current channel completes through CAPTURE. NEXT then goes to IDLE without issuing further channels, and scan_done still pulses.
- The period counter decrements every cycle while nonzero, independent of state. If it reaches 0 while a scan is still active, overrun is set and the next scan starts immediately on return to IDLE.
- If cfg_mask=0 with cfg_en=1, the block stays in IDLE with no commands and no scan_done.
- PRESET asserted mid-scan forces all reset values on the next edge. No res_valid is produced for an incomplete channel.

## Timing
- The first core_cmd START appears 1 cycle after the IDLE->ISSUE decision edge.
- Per channel: 1 (ISSUE) + N (WAIT, N≥1, done sampled from the first WAIT cycle) + 1 (CAPTURE) + 1 (NEXT).
- res_valid is registered and lands exactly in the CAPTURE cycle.
- scan_done is high in the NEXT cycle of the last channel.
- START is high for exactly one cycle per channel. No handshake back-pressure exists on res_valid: the buffer must accept one write every 4 cycles minimum.
- Arithmetic: counters are unsigned and do not wrap, saturating at 0. A timeout of 0 means 256 cycles.

## Structure
- Shared package acq_pkg holds:
  - the state enum
  - command field constants CMD_START_BIT=31, CMD_CH_LSB=8, CMD_OP_LSB=0
  - status bit indices DONE=0, ERR=1, BUSY=2
- One sub-module, acq_next_chan: combinational priority finder returning the next set mask bit above the current index, plus a found flag.

## Test plan
- mask=8'b0000_0101, op=4'h3, period=100, core done 3 cycles after START -> START commands for ch0 then ch2; two res_valid writes with chans 0 and 2; scan_done 1 cycle after the second CAPTURE; next scan starts at cycle 100.
- mask=8'h01, timeout=5, done never asserted -> after 5 WAIT cycles, res_valid with res_err=1 and res_data=0.
- period=4 with 3 channels active -> overrun=1 and scans run back-to-back; overrun clears on a cfg_en 0->1 toggle.
- cfg_en dropped during WAIT of ch1 out of {1,4,7} -> ch1 written, ch4 and ch7 never issued, scan_done pulses, busy=0.
- PRESET pulsed during WAIT -> next cycle all outputs at reset values and no res_valid for that channel; mask=0 afterwards -> no activity.
- done and timeout in the same cycle with err_sticky=0 -> res_err=0 and res_data=core_result.
